// File: rtl/butterfly_if.sv
// Operand, twiddle and result bundle for one radix-2 butterfly.
// The master drives operands and en; the slave returns results and valid.
interface butterfly_if #(
  parameter int DATA_WIDTH = 8,
  parameter int EXPAND     = 9
);
  logic                         en;
  logic signed [DATA_WIDTH-1:0] in1_real;
  logic signed [DATA_WIDTH-1:0] in1_imag;
  logic signed [DATA_WIDTH-1:0] in2_real;
  logic signed [DATA_WIDTH-1:0] in2_imag;
  logic signed [EXPAND+1:0]     ro_real;
  logic signed [EXPAND+1:0]     ro_imag;
  logic signed [DATA_WIDTH:0]   out1_real;
  logic signed [DATA_WIDTH:0]   out1_imag;
  logic signed [DATA_WIDTH:0]   out2_real;
  logic signed [DATA_WIDTH:0]   out2_imag;
  logic                         valid;

  modport master (
    output en, in1_real, in1_imag, in2_real, in2_imag, ro_real, ro_imag,
    input  out1_real, out1_imag, out2_real, out2_imag, valid
  );

  modport slave (
    input  en, in1_real, in1_imag, in2_real, in2_imag, ro_real, ro_imag,
    output out1_real, out1_imag, out2_real, out2_imag, valid
  );
endinterface

// File: rtl/butterfly.sv
// Radix-2 DIT butterfly: out1 = A + B*W, out2 = A - B*W, two-stage pipeline.
// Twiddle W is fixed point with EXPAND fraction bits; results floor-descaled and wrapped.
module butterfly #(
  parameter int DATA_WIDTH = 8,
  parameter int EXPAND     = 9
) (
  input logic       clk,
  input logic       rst_n,
  butterfly_if.slave bus
);
  localparam int PW = DATA_WIDTH + EXPAND + 3;
  localparam int OW = DATA_WIDTH + 1;

  logic signed [PW-1:0] w_br, w_bi, w_wr, w_wi;
  logic signed [PW-1:0] w_pr, w_pi;
  logic signed [PW-1:0] w_s1r, w_s1i, w_s2r, w_s2i;

  logic signed [PW-1:0] r_pr, r_pi, r_ar, r_ai;
  logic                 r_v1;

  assign w_br = PW'(bus.in2_real);
  assign w_bi = PW'(bus.in2_imag);
  assign w_wr = PW'(bus.ro_real);
  assign w_wi = PW'(bus.ro_imag);

  assign w_pr = w_br * w_wr - w_bi * w_wi;
  assign w_pi = w_br * w_wi + w_bi * w_wr;

  assign w_s1r = r_ar + r_pr;
  assign w_s1i = r_ai + r_pi;
  assign w_s2r = r_ar - r_pr;
  assign w_s2i = r_ai - r_pi;

  // Stage 1: full-precision product and A aligned to the twiddle scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pr <= '0;
      r_pi <= '0;
      r_ar <= '0;
      r_ai <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= bus.en;
      if (bus.en) begin
        r_pr <= w_pr;
        r_pi <= w_pi;
        r_ar <= PW'(bus.in1_real) <<< EXPAND;
        r_ai <= PW'(bus.in1_imag) <<< EXPAND;
      end
    end
  end

  // Stage 2: arithmetic shift floors toward -inf, then the cast wraps to OW bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out1_real <= '0;
      bus.out1_imag <= '0;
      bus.out2_real <= '0;
      bus.out2_imag <= '0;
      bus.valid     <= 1'b0;
    end else begin
      bus.valid <= r_v1;
      if (r_v1) begin
        bus.out1_real <= OW'(w_s1r >>> EXPAND);
        bus.out1_imag <= OW'(w_s1i >>> EXPAND);
        bus.out2_real <= OW'(w_s2r >>> EXPAND);
        bus.out2_imag <= OW'(w_s2i >>> EXPAND);
      end
    end
  end
endmodule

// File: tb/tb_butterfly.sv
// Self-checking bench for butterfly: directed plan vectors, streaming, random traffic and reset.
// Expected results come from exact integer arithmetic with explicit floor and wrap.
module tb_butterfly;
  localparam int DW  = 8;
  localparam int EX  = 9;
  localparam int ONE = 1 << EX;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  butterfly_if #(.DATA_WIDTH(DW), .EXPAND(EX)) bus ();

  butterfly #(.DATA_WIDTH(DW), .EXPAND(EX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input logic e);
    bus.in1_real = DW'(ar);
    bus.in1_imag = DW'(ai);
    bus.in2_real = DW'(br);
    bus.in2_imag = DW'(bi);
    bus.ro_real  = (EX+2)'(wr);
    bus.ro_imag  = (EX+2)'(wi);
    bus.en       = e;
  endtask

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / ONE;
    if (s < 0 && q * ONE != s) q = q - 1;
    return q;
  endfunction

  function automatic logic [DW:0] wrap_out(input longint q);
    longint m;
    m = q % (2 * (1 << DW));
    if (m < 0) m = m + 2 * (1 << DW);
    return m[DW:0];
  endfunction

  function automatic logic [4*(DW+1)-1:0] model(input int ar, input int ai, input int br,
                                                 input int bi, input int wr, input int wi);
    longint pr, pi, sar, sai;
    pr  = longint'(br) * wr - longint'(bi) * wi;
    pi  = longint'(br) * wi + longint'(bi) * wr;
    sar = longint'(ar) * ONE;
    sai = longint'(ai) * ONE;
    return {wrap_out(floor_div(sar + pr)), wrap_out(floor_div(sai + pi)),
            wrap_out(floor_div(sar - pr)), wrap_out(floor_div(sai - pi))};
  endfunction

  function automatic logic [4*(DW+1)-1:0] outs();
    return {bus.out1_real, bus.out1_imag, bus.out2_real, bus.out2_imag};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h expected 0", outs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int v[5][6] = '{'{10, 5, 3, -2, 512, 0},
                    '{10, 5, 3, -2, 0, 512},
                    '{127, 0, 127, 0, 512, 0},
                    '{-128, 0, 127, 0, -512, 0},
                    '{0, 0, 1, 0, 362, -362}};
    int e[5][4] = '{'{13, 3, 7, 7},
                    '{12, 8, 8, 2},
                    '{254, 0, 0, 0},
                    '{-255, 0, -1, 0},
                    '{0, -1, -1, 0}};
    logic [4*(DW+1)-1:0] exp_o;
    for (int k = 0; k < 5; k++) begin
      exp_o = {(DW+1)'(e[k][0]), (DW+1)'(e[k][1]), (DW+1)'(e[k][2]), (DW+1)'(e[k][3])};
      drive(v[k][0], v[k][1], v[k][2], v[k][3], v[k][4], v[k][5], 1'b1);
      tick();
      n_checks++;
      if (bus.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_early_valid: got %b expected 0", k, bus.valid);
      end
      drive(0, 0, 0, 0, 0, 0, 1'b0);
      tick();
      n_checks++;
      if (bus.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL directed%0d_valid: got %b expected 1", k, bus.valid);
      end
      n_checks++;
      if (outs() !== exp_o) begin
        n_fail++;
        $display("FAIL directed%0d_result: got %h expected %h", k, outs(), exp_o);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || outs() !== exp_o) begin
        n_fail++;
        $display("FAIL directed%0d_hold: got valid=%b outs=%h expected valid=0 outs=%h",
                 k, bus.valid, outs(), exp_o);
      end
    end
  endtask

  task automatic test_stream();
    logic [4*(DW+1)-1:0] q[$];
    logic [4*(DW+1)-1:0] exp_o;
    int ar, ai, br, bi;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        ar = i * 13 - 50;
        ai = 40 - i * 11;
        br = 7 * i - 20;
        bi = 3 - 5 * i;
        q.push_back(model(ar, ai, br, bi, 362, 362));
        drive(ar, ai, br, bi, 362, 362, 1'b1);
      end else begin
        drive(0, 0, 0, 0, 0, 0, 1'b0);
      end
      tick();
      n_checks++;
      if (bus.valid !== (i >= 1 && i <= 8)) begin
        n_fail++;
        $display("FAIL stream_valid%0d: got %b expected %b", i, bus.valid, (i >= 1 && i <= 8));
      end
      if (i >= 1 && i <= 8 && q.size() > 0) begin
        exp_o = q.pop_front();
        n_checks++;
        if (outs() !== exp_o) begin
          n_fail++;
          $display("FAIL stream_result%0d: got %h expected %h", i - 1, outs(), exp_o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [4*(DW+1)-1:0] q[$];
    logic [4*(DW+1)-1:0] last;
    logic [4*(DW+1)-1:0] exp_o;
    logic e, en_prev;
    bit   have_last;
    int   ar, ai, br, bi, wr, wi;
    en_prev   = 1'b0;
    have_last = 1'b0;
    last      = '0;
    for (int i = 0; i < 80; i++) begin
      e  = (i < 78) ? 1'($urandom_range(1)) : 1'b0;
      ar = int'($urandom_range(255)) - 128;
      ai = int'($urandom_range(255)) - 128;
      br = int'($urandom_range(255)) - 128;
      bi = int'($urandom_range(255)) - 128;
      wr = int'($urandom_range(1024)) - 512;
      wi = int'($urandom_range(1024)) - 512;
      if (e) q.push_back(model(ar, ai, br, bi, wr, wi));
      drive(ar, ai, br, bi, wr, wi, e);
      tick();
      n_checks++;
      if (bus.valid !== en_prev) begin
        n_fail++;
        $display("FAIL random_valid%0d: got %b expected %b", i, bus.valid, en_prev);
      end
      if (en_prev && q.size() > 0) begin
        exp_o = q.pop_front();
        last = exp_o;
        have_last = 1'b1;
        n_checks++;
        if (outs() !== exp_o) begin
          n_fail++;
          $display("FAIL random_result%0d: got %h expected %h", i, outs(), exp_o);
        end
      end else if (have_last) begin
        n_checks++;
        if (outs() !== last) begin
          n_fail++;
          $display("FAIL random_hold%0d: got %h expected %h", i, outs(), last);
        end
      end
      en_prev = e;
    end
  endtask

  task automatic test_reset_midflight();
    logic [4*(DW+1)-1:0] exp_o;
    drive(20, -30, 11, 9, 512, 0, 1'b1);
    tick();
    // token in stage 1; reset now, with en high that must be ignored
    rst_n = 1'b0;
    drive(-7, 8, 60, -60, 0, 512, 1'b1);
    tick();
    n_checks++;
    if (bus.valid !== 1'b0 || outs() !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%b outs=%h expected valid=0 outs=0",
               bus.valid, outs());
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || outs() !== '0) begin
        n_fail++;
        $display("FAIL midreset_flushed%0d: got valid=%b outs=%h expected valid=0 outs=0",
                 i, bus.valid, outs());
      end
    end
    exp_o = model(-45, 33, -17, 100, -300, 401);
    drive(-45, 33, -17, 100, -300, 401, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    tick();
    n_checks++;
    if (bus.valid !== 1'b1 || outs() !== exp_o) begin
      n_fail++;
      $display("FAIL postreset_token: got valid=%b outs=%h expected valid=1 outs=%h",
               bus.valid, outs(), exp_o);
    end
  endtask

  task automatic test_first_after_release();
    logic [4*(DW+1)-1:0] exp_o;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_o = model(-100, 90, -128, 127, 0, -512);
    drive(-100, 90, -128, 127, 0, -512, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    tick();
    n_checks++;
    if (bus.valid !== 1'b1 || outs() !== exp_o) begin
      n_fail++;
      $display("FAIL first_accept: got valid=%b outs=%h expected valid=1 outs=%h",
               bus.valid, outs(), exp_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_random();
    test_reset_midflight();
    test_first_after_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
